// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-cycle-latency memory between instruction fetch and
// load/store traffic. The data port wins by default; a starved fetch port is forced through.
module mem_arbiter #(
    parameter int unsigned AW           = 16,
    parameter int unsigned DW           = 16,
    parameter int unsigned STARVE_LIMIT = 3,
    parameter int unsigned CW           = 16
) (
    input  logic          clk,
    input  logic          rst,
    // Instruction fetch port
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    // Load/store port
    input  logic          d_req,
    input  logic          d_wen,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    // Shared memory
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    // Stall statistics
    output logic [CW-1:0] i_stall_cnt,
    output logic [CW-1:0] d_stall_cnt
);

    localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] StarveMax = SW'(STARVE_LIMIT);
    localparam logic [CW-1:0] StallMax  = '1;

    typedef enum logic [0:0] {
        StNormal,
        StForceI
    } state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [CW-1:0] i_stall_q, i_stall_d;
    logic [CW-1:0] d_stall_q, d_stall_d;
    logic [AW-1:0] addr_q;
    logic [1:0]    owner_q, owner_d;
    logic          force_i;

    // Grant decode and memory-side muxing; nothing here is registered.
    always_comb begin
        force_i   = (state_q == StForceI) & i_req;
        d_gnt     = ~rst & d_req & ~force_i;
        i_gnt     = ~rst & i_req & ~(d_req & ~force_i);
        mem_wen   = d_gnt & d_wen;
        mem_wdata = d_wdata;
        mem_addr  = addr_q;
        if (rst) begin
            mem_addr = '0;
        end else if (i_gnt) begin
            mem_addr = i_addr;
        end else if (d_gnt) begin
            mem_addr = d_addr;
        end
        i_rvalid = owner_q[1] & ~rst;
        d_rvalid = owner_q[0] & ~rst;
        i_rdata  = mem_rdata;
        d_rdata  = mem_rdata;
    end

    always_comb begin
        starve_d  = '0;
        state_d   = StNormal;
        i_stall_d = i_stall_q;
        d_stall_d = d_stall_q;
        owner_d   = {i_gnt, d_gnt & ~d_wen};

        if (i_req && !i_gnt) begin
            starve_d = (starve_q == StarveMax) ? starve_q : starve_q + SW'(1);
        end
        unique case (starve_d == StarveMax)
            1'b1:    state_d = StForceI;
            default: state_d = StNormal;
        endcase

        if (i_req && !i_gnt && (i_stall_q != StallMax)) begin
            i_stall_d = i_stall_q + CW'(1);
        end
        if (d_req && !d_gnt && (d_stall_q != StallMax)) begin
            d_stall_d = d_stall_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StNormal;
            starve_q  <= '0;
            i_stall_q <= '0;
            d_stall_q <= '0;
            addr_q    <= '0;
            owner_q   <= '0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            i_stall_q <= i_stall_d;
            d_stall_q <= d_stall_d;
            addr_q    <= mem_addr;
            owner_q   <= owner_d;
        end
    end

    assign i_stall_cnt = i_stall_q;
    assign d_stall_cnt = d_stall_q;

    a_one_grant: assert property (@(posedge clk) !(i_gnt && d_gnt));
    a_wen_only_on_store: assert property (@(posedge clk) mem_wen |-> (d_gnt && d_wen));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-scenario tasks with inline checks, plus a read-return
// scoreboard fed by the tasks and drained by a monitor.
module tb_mem_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, i_gnt, i_rvalid;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          d_req, d_wen, d_gnt, d_rvalid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [15:0]   i_stall_cnt, d_stall_cnt;

    mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(3), .CW(16)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .i_stall_cnt(i_stall_cnt), .d_stall_cnt(d_stall_cnt)
    );

    always #5 clk = ~clk;

    // Memory environment: registered read of the address presented this cycle.
    logic [DW-1:0] mem     [0:255];
    logic [DW-1:0] ref_mem [0:255];
    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr[7:0]];
        if (mem_wen) mem[mem_addr[7:0]] = mem_wdata;
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned   cyc;
        bit            port_i;
        logic [DW-1:0] data;
    } exp_t;
    exp_t          sb[$];
    exp_t          mon_e;
    bit            mon_ei, mon_ed;
    logic [DW-1:0] mon_dat;

    always @(negedge clk) begin
        mon_ei  = 1'b0;
        mon_ed  = 1'b0;
        mon_dat = '0;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            mon_e = sb.pop_front();
            n_fail++;
            $display("FAIL sb_lost: expected return at cycle %0d not seen (now %0d)", mon_e.cyc, cyc);
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            mon_e   = sb.pop_front();
            mon_ei  = mon_e.port_i;
            mon_ed  = !mon_e.port_i;
            mon_dat = mon_e.data;
        end
        n_checks++;
        if (i_rvalid !== mon_ei) begin
            n_fail++; $display("FAIL sb_i_rvalid cyc %0d: got %b want %b", cyc, i_rvalid, mon_ei);
        end
        n_checks++;
        if (d_rvalid !== mon_ed) begin
            n_fail++; $display("FAIL sb_d_rvalid cyc %0d: got %b want %b", cyc, d_rvalid, mon_ed);
        end
        if (mon_ei) begin
            n_checks++;
            if (i_rdata !== mon_dat) begin
                n_fail++; $display("FAIL sb_i_rdata cyc %0d: got %h want %h", cyc, i_rdata, mon_dat);
            end
        end
        if (mon_ed) begin
            n_checks++;
            if (d_rdata !== mon_dat) begin
                n_fail++; $display("FAIL sb_d_rdata cyc %0d: got %h want %h", cyc, d_rdata, mon_dat);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_req = 1'b0;
        d_req = 1'b0;
        d_wen = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_req = 1'b1; i_addr = 16'h0004;
        d_req = 1'b1; d_wen = 1'b1; d_addr = 16'h0030; d_wdata = 16'hDEAD;
        repeat (2) begin
            step();
            @(negedge clk);
            n_checks++; if (i_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_i_gnt got %b want 0", i_gnt); end
            n_checks++; if (d_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_d_gnt got %b want 0", d_gnt); end
            n_checks++; if (mem_wen !== 1'b0) begin n_fail++; $display("FAIL rst_mem_wen got %b want 0", mem_wen); end
            n_checks++; if (mem_addr !== 16'h0) begin n_fail++; $display("FAIL rst_mem_addr got %h want 0", mem_addr); end
            n_checks++; if (i_stall_cnt !== 16'h0) begin n_fail++; $display("FAIL rst_i_stall got %h want 0", i_stall_cnt); end
            n_checks++; if (d_stall_cnt !== 16'h0) begin n_fail++; $display("FAIL rst_d_stall got %h want 0", d_stall_cnt); end
        end
        // First cycle out of reset must already grant.
        step();
        rst = 1'b0; i_req = 1'b0; d_req = 1'b1; d_wen = 1'b0; d_addr = 16'h0008;
        sb.push_back('{cyc + 1, 1'b0, ref_mem[8]});
        @(negedge clk);
        n_checks++; if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL first_gnt got %b want 1", d_gnt); end
        n_checks++; if (mem_addr !== 16'h0008) begin n_fail++; $display("FAIL first_addr got %h want 0008", mem_addr); end
        step();
        idle();
    endtask

    task automatic test_ifetch();
        step();
        i_req = 1'b1; i_addr = 16'h0004;
        sb.push_back('{cyc + 1, 1'b1, 16'h1234});
        @(negedge clk);
        n_checks++; if (i_gnt !== 1'b1) begin n_fail++; $display("FAIL if_i_gnt got %b want 1", i_gnt); end
        n_checks++; if (d_gnt !== 1'b0) begin n_fail++; $display("FAIL if_d_gnt got %b want 0", d_gnt); end
        n_checks++; if (mem_addr !== 16'h0004) begin n_fail++; $display("FAIL if_addr got %h want 0004", mem_addr); end
        step();
        idle();
        @(negedge clk);
        n_checks++; if (mem_addr !== 16'h0004) begin n_fail++; $display("FAIL if_addr_hold got %h want 0004", mem_addr); end
        n_checks++; if (i_gnt !== 1'b0) begin n_fail++; $display("FAIL if_idle_gnt got %b want 0", i_gnt); end
    endtask

    task automatic test_store_load();
        step();
        d_req = 1'b1; d_wen = 1'b1; d_addr = 16'h0010; d_wdata = 16'hBEEF;
        ref_mem[8'h10] = 16'hBEEF;
        @(negedge clk);
        n_checks++; if (mem_wen !== 1'b1) begin n_fail++; $display("FAIL st_wen got %b want 1", mem_wen); end
        n_checks++; if (mem_wdata !== 16'hBEEF) begin n_fail++; $display("FAIL st_wdata got %h want beef", mem_wdata); end
        n_checks++; if (mem_addr !== 16'h0010) begin n_fail++; $display("FAIL st_addr got %h want 0010", mem_addr); end
        step();
        d_wen = 1'b0;
        sb.push_back('{cyc + 1, 1'b0, 16'hBEEF});
        @(negedge clk);
        n_checks++; if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL ld_gnt got %b want 1", d_gnt); end
        n_checks++; if (mem_wen !== 1'b0) begin n_fail++; $display("FAIL ld_wen got %b want 0", mem_wen); end
        step();
        idle();
        @(negedge clk);
        n_checks++; if (mem_wen !== 1'b0) begin n_fail++; $display("FAIL ld_wen2 got %b want 0", mem_wen); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            step();
            i_req = (k % 2 == 0);
            d_req = (k % 2 == 1);
            d_wen = 1'b0;
            i_addr = 16'(16'h0050 + k);
            d_addr = 16'(16'h0060 + k);
            if (i_req) sb.push_back('{cyc + 1, 1'b1, ref_mem[i_addr[7:0]]});
            else       sb.push_back('{cyc + 1, 1'b0, ref_mem[d_addr[7:0]]});
            @(negedge clk);
            n_checks++;
            if ({i_gnt, d_gnt} !== {i_req, d_req}) begin
                n_fail++; $display("FAIL b2b_gnt k=%0d got %b%b want %b%b", k, i_gnt, d_gnt, i_req, d_req);
            end
        end
        step();
        idle();
    endtask

    task automatic test_starve();
        int scnt = 0, is_m = 0, ij = 0, dj = 0;
        bit iw;
        step(); rst = 1'b1; idle();
        step(); rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            i_req = 1'b1; i_addr = 16'(16'h0040 + ij);
            d_req = 1'b1; d_wen = ~dj[0];
            d_addr = 16'(16'h0020 + dj / 2); d_wdata = 16'(16'hA000 + dj);
            iw = (scnt == 3);
            if (iw)         sb.push_back('{cyc + 1, 1'b1, ref_mem[i_addr[7:0]]});
            else if (d_wen) ref_mem[d_addr[7:0]] = d_wdata;
            else            sb.push_back('{cyc + 1, 1'b0, ref_mem[d_addr[7:0]]});
            @(negedge clk);
            n_checks++; if (i_gnt !== iw) begin n_fail++; $display("FAIL stv_i_gnt c=%0d got %b want %b", c, i_gnt, iw); end
            n_checks++; if (d_gnt !== !iw) begin n_fail++; $display("FAIL stv_d_gnt c=%0d got %b want %b", c, d_gnt, !iw); end
            n_checks++;
            if (mem_wen !== (!iw && d_wen)) begin
                n_fail++; $display("FAIL stv_wen c=%0d got %b want %b", c, mem_wen, !iw && d_wen);
            end
            n_checks++;
            if (mem_addr !== (iw ? i_addr : d_addr)) begin
                n_fail++; $display("FAIL stv_addr c=%0d got %h want %h", c, mem_addr, iw ? i_addr : d_addr);
            end
            n_checks++;
            if (i_stall_cnt !== 16'(is_m)) begin
                n_fail++; $display("FAIL stv_i_stall c=%0d got %0d want %0d", c, i_stall_cnt, is_m);
            end
            if (iw) begin scnt = 0; ij++; end
            else begin scnt++; is_m++; dj++; end
            step();
        end
        idle();
        @(negedge clk);
        n_checks++; if (i_stall_cnt !== 16'd9) begin n_fail++; $display("FAIL stv_i_total got %0d want 9", i_stall_cnt); end
        n_checks++; if (d_stall_cnt !== 16'd3) begin n_fail++; $display("FAIL stv_d_total got %0d want 3", d_stall_cnt); end
        step();
    endtask

    task automatic test_reset_pending();
        d_req = 1'b1; d_wen = 1'b0; d_addr = 16'h0021;
        @(negedge clk);
        n_checks++; if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL rp_gnt got %b want 1", d_gnt); end
        step();
        rst = 1'b1; idle();
        @(negedge clk);
        n_checks++; if (d_rvalid !== 1'b0) begin n_fail++; $display("FAIL rp_rvalid_rst got %b want 0", d_rvalid); end
        step();
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (d_rvalid !== 1'b0) begin n_fail++; $display("FAIL rp_rvalid_after got %b want 0", d_rvalid); end
        n_checks++; if (i_stall_cnt !== 16'h0) begin n_fail++; $display("FAIL rp_i_stall got %h want 0", i_stall_cnt); end
        n_checks++; if (d_stall_cnt !== 16'h0) begin n_fail++; $display("FAIL rp_d_stall got %h want 0", d_stall_cnt); end
        step();
    endtask

    task automatic test_saturate();
        int scnt = 0, ij = 0, dj = 0;
        logic [15:0] ds = 16'hFFFE;
        bit iw;
        @(negedge clk);
        dut.d_stall_q <= 16'hFFFE;
        step();
        for (int c = 0; c < 12; c++) begin
            i_req = 1'b1; i_addr = 16'(16'h0080 + ij);
            d_req = 1'b1; d_wen = 1'b1;
            d_addr = 16'(16'h0070 + dj); d_wdata = 16'(16'hC000 + dj);
            iw = (scnt == 3);
            if (iw) sb.push_back('{cyc + 1, 1'b1, ref_mem[i_addr[7:0]]});
            else    ref_mem[d_addr[7:0]] = d_wdata;
            @(negedge clk);
            n_checks++; if (d_gnt !== !iw) begin n_fail++; $display("FAIL sat_d_gnt c=%0d got %b want %b", c, d_gnt, !iw); end
            n_checks++;
            if (d_stall_cnt !== ds) begin
                n_fail++; $display("FAIL sat_d_stall c=%0d got %h want %h", c, d_stall_cnt, ds);
            end
            if (iw) begin scnt = 0; ij++; ds = (ds == 16'hFFFF) ? ds : ds + 16'd1; end
            else begin scnt++; dj++; end
            step();
        end
        idle();
        @(negedge clk);
        n_checks++; if (d_stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_final got %h want ffff", d_stall_cnt); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 16'(i * 257) ^ 16'h5A5A;
            ref_mem[i] = mem[i];
        end
        mem[4] = 16'h1234; ref_mem[4] = 16'h1234;
        rst = 1'b1; i_addr = '0; d_addr = '0; d_wdata = '0;
        idle();

        test_reset();
        test_ifetch();
        test_store_load();
        test_back_to_back();
        test_starve();
        test_reset_pending();
        test_saturate();

        repeat (3) step();
        n_checks++;
        if (sb.size() !== 0) begin n_fail++; $display("FAIL sb_drain got %0d pending want 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
